// File: rtl/alu_issue_if.sv
// alu_issue_if: op-in and result-out valid/ready handshakes of alu_issue_stage
interface alu_issue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_command;
  logic [WIDTH-1:0] in_operand_a;
  logic [WIDTH-1:0] in_operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carryout;
  logic             out_zero;
  logic             out_overflow;
  modport master (
    output in_valid, in_command, in_operand_a, in_operand_b, out_ready,
    input  in_ready, out_valid, out_result, out_carryout, out_zero, out_overflow
  );
  modport slave (
    input  in_valid, in_command, in_operand_a, in_operand_b, out_ready,
    output in_ready, out_valid, out_result, out_carryout, out_zero, out_overflow
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue/retire stage around a combinational ALU with result FIFO and sticky status
// Optional accumulator operand forwarding is enabled by defining ALU_ISSUE_ACC_EN.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_if.slave       io,
`ifdef ALU_ISSUE_ACC_EN
  input  logic             in_use_acc,
`endif
  output logic [2:0]       alu_command,
  output logic [WIDTH-1:0] alu_operand_a,
  output logic [WIDTH-1:0] alu_operand_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             clr_sticky,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count
);
  localparam int aw = $clog2(DEPTH);
  localparam logic [aw:0] full = DEPTH[aw:0];
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;
  } entry_t;
  entry_t           mem [DEPTH];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic [aw:0]      count;
  logic             ex_valid, in_fire, ex_fire, pop;
  logic [WIDTH-1:0] cap_a;
  assign pop         = io.out_valid & io.out_ready;
  assign ex_fire     = ex_valid & ((count < full) | pop);
  assign io.in_ready = ~ex_valid | ex_fire;
  assign in_fire     = io.in_valid & io.in_ready;
`ifdef ALU_ISSUE_ACC_EN
  logic [WIDTH-1:0] acc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else if (ex_fire) acc_q <= alu_result;
  // the retiring op's result is not in acc_q yet, so forward it directly
  assign cap_a = in_use_acc ? (ex_fire ? alu_result : acc_q) : io.in_operand_a;
`else
  assign cap_a = io.in_operand_a;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      alu_command   <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
    end else begin
      ex_valid <= in_fire | (ex_valid & ~ex_fire);
      if (in_fire) begin
        alu_command   <= io.in_command;
        alu_operand_a <= cap_a;
        alu_operand_b <= io.in_operand_b;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (ex_fire) begin
        mem[wr_ptr] <= {alu_result, alu_carryout, alu_zero, alu_overflow};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (ex_fire & ~pop) ? count + 1'b1 : (~ex_fire & pop) ? count - 1'b1 : count;
    end
  assign io.out_valid    = |count;
  assign io.out_result   = mem[rd_ptr].result;
  assign io.out_carryout = mem[rd_ptr].carryout;
  assign io.out_zero     = mem[rd_ptr].zero;
  assign io.out_overflow = mem[rd_ptr].overflow;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      op_count   <= '0;
    end else begin
      ovf_sticky <= (ex_fire & alu_overflow) | (ovf_sticky & ~clr_sticky);
      if (ex_fire) op_count <= op_count + 1'b1;
    end
endmodule
